// File: rtl/bigseg_access_ctrl_if.sv
// rtl/bigseg_access_ctrl_if.sv - lookup and rule-update stream bundle for bigseg_access_ctrl
interface bigseg_access_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             lk_valid;
    logic             lk_ready;
    logic [10:0]      lk_seg_index;
    logic             lk_smallorbig;
    logic [103:0]     lk_tuple;
    logic [TAG_W-1:0] lk_tag;
    logic             up_valid;
    logic             up_ready;
    logic [10:0]      up_seg_index;
    logic [59:0]      up_data;

    modport master (
        output lk_valid, lk_seg_index, lk_smallorbig, lk_tuple, lk_tag,
        output up_valid, up_seg_index, up_data,
        input  lk_ready, up_ready
    );

    modport slave (
        input  lk_valid, lk_seg_index, lk_smallorbig, lk_tuple, lk_tag,
        input  up_valid, up_seg_index, up_data,
        output lk_ready, up_ready
    );
endinterface

// File: rtl/bigseg_access_ctrl.sv
// rtl/bigseg_access_ctrl.sv - shares the big segment table port between lookups and buffered rule updates
module bigseg_access_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int STARVE_MAX  = 8,
    parameter int TAG_W       = 4,
    parameter int BIG_SEG_NUM = 184
) (
    input  logic             clk,
    input  logic             rst,
    bigseg_access_ctrl_if.slave bus,
    input  logic             cfg_freeze,
    output logic             cfg_drained,
    output logic [10:0]      tbl_segment_index,
    output logic             tbl_smallorbig,
    output logic [103:0]     tbl_tuple,
    output logic             tbl_we,
    output logic [59:0]      tbl_din,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic             up_err,
    output logic [15:0]      up_commit_cnt
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [10:0] SEG_LIMIT = 11'(BIG_SEG_NUM);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FROZEN} state_t;
    state_t state, state_nx;

    logic [10:0]      fifo_idx  [FIFO_DEPTH];
    logic [59:0]      fifo_data [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [SW-1:0]    starve_cnt;
    logic             p1_valid;
    logic [TAG_W-1:0] p1_tag;

    logic        fifo_empty, fifo_full, starve_at_max;
    logic        up_grant, lk_grant, push, head_in_range, pipe_empty;
    logic [10:0] head_idx;
    logic [59:0] head_data;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign starve_at_max = (starve_cnt == SW'(STARVE_MAX));
    assign head_idx      = fifo_idx[rd_ptr[AW-1:0]];
    assign head_data     = fifo_data[rd_ptr[AW-1:0]];
    assign head_in_range = (head_idx < SEG_LIMIT);
    assign pipe_empty    = !p1_valid && !res_valid;

    assign up_grant = !fifo_empty && (cfg_freeze || !bus.lk_valid || starve_at_max);
    assign lk_grant = !up_grant && bus.lk_valid && !cfg_freeze;
    assign push     = bus.up_valid && bus.up_ready;

    assign bus.lk_ready = !rst && !cfg_freeze && !(!fifo_empty && starve_at_max);
    assign bus.up_ready = !rst && !fifo_full;
    assign cfg_drained  = (state == S_FROZEN);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr[AW-1:0]]  <= bus.up_seg_index;
            fifo_data[wr_ptr[AW-1:0]] <= bus.up_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_RUN;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            starve_cnt        <= '0;
            tbl_segment_index <= '0;
            tbl_smallorbig    <= 1'b0;
            tbl_tuple         <= '0;
            tbl_we            <= 1'b0;
            tbl_din           <= '0;
            p1_valid          <= 1'b0;
            p1_tag            <= '0;
            res_valid         <= 1'b0;
            res_tag           <= '0;
            up_err            <= 1'b0;
            up_commit_cnt     <= '0;
        end else begin
            state          <= state_nx;
            tbl_we         <= 1'b0;
            tbl_smallorbig <= 1'b0;
            up_err         <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (up_grant) begin
                rd_ptr            <= rd_ptr + (AW+1)'(1);
                tbl_segment_index <= head_idx;
                tbl_din           <= head_data;
                if (head_in_range) begin
                    tbl_we        <= 1'b1;
                    up_commit_cnt <= up_commit_cnt + 16'd1;
                end else begin
                    up_err <= 1'b1;
                end
            end else if (lk_grant) begin
                tbl_segment_index <= bus.lk_seg_index;
                tbl_smallorbig    <= bus.lk_smallorbig;
                tbl_tuple         <= bus.lk_tuple;
            end
            // Starvation only accrues while an update is actually waiting.
            if (up_grant || fifo_empty)
                starve_cnt <= '0;
            else if (lk_grant && !starve_at_max)
                starve_cnt <= starve_cnt + SW'(1);
            p1_valid  <= lk_grant;
            if (lk_grant)
                p1_tag <= bus.lk_tag;
            res_valid <= p1_valid;
            if (p1_valid)
                res_tag <= p1_tag;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:    if (cfg_freeze) state_nx = S_DRAIN;
            S_DRAIN:  if (!cfg_freeze) state_nx = S_RUN;
                      else if (fifo_empty && pipe_empty) state_nx = S_FROZEN;
            S_FROZEN: if (!cfg_freeze) state_nx = S_RUN;
                      else if (!fifo_empty) state_nx = S_DRAIN;
            default:  state_nx = S_RUN;
        endcase
    end
endmodule

// File: tb/tb_bigseg_access_ctrl.sv
// tb/tb_bigseg_access_ctrl.sv - directed self-checking bench for bigseg_access_ctrl
module tb_bigseg_access_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_freeze;
    logic         cfg_drained;
    logic [10:0]  tbl_segment_index;
    logic         tbl_smallorbig;
    logic [103:0] tbl_tuple;
    logic         tbl_we;
    logic [59:0]  tbl_din;
    logic         res_valid;
    logic [3:0]   res_tag;
    logic         up_err;
    logic [15:0]  up_commit_cnt;

    int checks = 0;
    int errors = 0;

    bigseg_access_ctrl_if #(.TAG_W(4)) bus ();

    bigseg_access_ctrl #(
        .FIFO_DEPTH(4), .STARVE_MAX(8), .TAG_W(4), .BIG_SEG_NUM(184)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .cfg_freeze(cfg_freeze), .cfg_drained(cfg_drained),
        .tbl_segment_index(tbl_segment_index), .tbl_smallorbig(tbl_smallorbig),
        .tbl_tuple(tbl_tuple), .tbl_we(tbl_we), .tbl_din(tbl_din),
        .res_valid(res_valid), .res_tag(res_tag), .up_err(up_err), .up_commit_cnt(up_commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [103:0] tuple_a;
    int n, pushed, wr_n, seen;
    logic exp_wr, acc;

    initial begin
        tuple_a = 104'hABCDEF0123456789ABCDEF0123;
        rst = 1'b1; cfg_freeze = 1'b0;
        bus.lk_valid = 1'b0; bus.lk_seg_index = '0; bus.lk_smallorbig = 1'b0;
        bus.lk_tuple = '0; bus.lk_tag = '0;
        bus.up_valid = 1'b0; bus.up_seg_index = '0; bus.up_data = '0;
        tick(); tick();
        check("rst_lk_ready", bus.lk_ready, 1'b0);
        check("rst_up_ready", bus.up_ready, 1'b0);
        check("rst_tbl", {tbl_we, tbl_smallorbig, tbl_segment_index, tbl_din}, '0);
        check("rst_tuple", tbl_tuple, '0);
        check("rst_res", {res_valid, res_tag, up_err, cfg_drained}, '0);
        check("rst_cnt", up_commit_cnt, 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_lk_ready", bus.lk_ready, 1'b1);
        check("post_rst_up_ready", bus.up_ready, 1'b1);

        // Single big lookup: tbl_* one cycle after accept, result two cycles after.
        bus.lk_valid = 1'b1; bus.lk_seg_index = 11'd5; bus.lk_smallorbig = 1'b1;
        bus.lk_tuple = tuple_a; bus.lk_tag = 4'd3;
        check("t1_lk_ready", bus.lk_ready, 1'b1);
        tick();
        bus.lk_valid = 1'b0;
        check("t1_smallorbig", tbl_smallorbig, 1'b1);
        check("t1_seg", tbl_segment_index, 11'd5);
        check("t1_tuple", tbl_tuple, tuple_a);
        check("t1_we", tbl_we, 1'b0);
        check("t1_res_early", res_valid, 1'b0);
        tick();
        check("t1_res_valid", res_valid, 1'b1);
        check("t1_res_tag", res_tag, 4'd3);
        check("t1_idle_smallorbig", tbl_smallorbig, 1'b0);
        tick();
        check("t1_res_once", res_valid, 1'b0);

        // Continuous lookups with one pending update: 8 grants then a forced write.
        bus.lk_valid = 1'b1; bus.lk_smallorbig = 1'b0; bus.lk_seg_index = 11'd9;
        bus.up_valid = 1'b1; bus.up_seg_index = 11'd7; bus.up_data = 60'hDEAD_BEEF;
        tick();
        bus.up_valid = 1'b0;
        n = 0;
        while (bus.lk_ready && n < 20) begin
            n++;
            tick();
        end
        check("t2_lookup_grants", n, 8);
        tick();
        check("t2_we", tbl_we, 1'b1);
        check("t2_seg", tbl_segment_index, 11'd7);
        check("t2_din", tbl_din, 60'hDEAD_BEEF);
        check("t2_smallorbig", tbl_smallorbig, 1'b0);
        check("t2_cnt", up_commit_cnt, 16'd1);
        check("t2_lk_ready_back", bus.lk_ready, 1'b1);

        // Fill the FIFO under lookup pressure; writes land every 9th cycle in order.
        pushed = 0; wr_n = 0;
        for (int c = 0; c < 50; c++) begin
            bus.up_valid = (pushed < 5);
            bus.up_seg_index = 11'(10 + pushed);
            bus.up_data = 60'(100 + pushed);
            if (c <= 10) check("t3_up_ready", bus.up_ready, (c <= 3 || c == 10));
            exp_wr = (c >= 9) && (c <= 45) && (c % 9 == 0);
            check("t3_lk_ready", bus.lk_ready, !exp_wr);
            acc = bus.up_valid && bus.up_ready;
            tick();
            if (acc) pushed++;
            check("t3_we", tbl_we, exp_wr);
            if (exp_wr) begin
                check("t3_seg", tbl_segment_index, 11'(10 + wr_n));
                check("t3_din", tbl_din, 60'(100 + wr_n));
                wr_n++;
            end
        end
        check("t3_writes", wr_n, 5);
        check("t3_cnt", up_commit_cnt, 16'd6);

        // Range boundary: 200 and 184 dropped with up_err, 183 committed.
        bus.lk_valid = 1'b0; bus.up_valid = 1'b0;
        tick(); tick(); tick();
        bus.up_valid = 1'b1; bus.up_seg_index = 11'd200; bus.up_data = 60'h1;
        tick();
        bus.up_seg_index = 11'd183; bus.up_data = 60'h2;
        tick();
        check("t4_err200", up_err, 1'b1);
        check("t4_we200", tbl_we, 1'b0);
        check("t4_cnt200", up_commit_cnt, 16'd6);
        bus.up_seg_index = 11'd184; bus.up_data = 60'h3;
        tick();
        bus.up_valid = 1'b0;
        check("t4_err183", up_err, 1'b0);
        check("t4_we183", tbl_we, 1'b1);
        check("t4_seg183", tbl_segment_index, 11'd183);
        check("t4_cnt183", up_commit_cnt, 16'd7);
        tick();
        check("t4_err184", up_err, 1'b1);
        check("t4_we184", tbl_we, 1'b0);
        check("t4_cnt184", up_commit_cnt, 16'd7);
        tick();
        check("t4_err_pulse", up_err, 1'b0);

        // Freeze with two lookups in flight and two updates queued.
        bus.lk_valid = 1'b1; bus.lk_seg_index = 11'd50; bus.lk_tag = 4'd1;
        bus.up_valid = 1'b1; bus.up_seg_index = 11'd20; bus.up_data = 60'd200;
        tick();
        bus.lk_tag = 4'd2; bus.up_seg_index = 11'd21; bus.up_data = 60'd201;
        check("t5_lk_ready_pre", bus.lk_ready, 1'b1);
        tick();
        check("t5_res1", {res_valid, res_tag}, {1'b1, 4'd1});
        bus.up_valid = 1'b0; cfg_freeze = 1'b1;
        #1;
        check("t5_lk_ready_frozen", bus.lk_ready, 1'b0);
        tick();
        check("t5_res2", {res_valid, res_tag}, {1'b1, 4'd2});
        check("t5_wr20", {tbl_we, tbl_segment_index}, {1'b1, 11'd20});
        check("t5_drained_a", cfg_drained, 1'b0);
        tick();
        check("t5_wr21", {tbl_we, tbl_segment_index}, {1'b1, 11'd21});
        check("t5_res_none", res_valid, 1'b0);
        check("t5_drained_b", cfg_drained, 1'b0);
        check("t5_cnt", up_commit_cnt, 16'd9);
        tick();
        check("t5_drained", cfg_drained, 1'b1);
        bus.up_valid = 1'b1; bus.up_seg_index = 11'd30; bus.up_data = 60'd300;
        check("t5_up_ready_frozen", bus.up_ready, 1'b1);
        tick();
        bus.up_valid = 1'b0;
        check("t5_drained_push", cfg_drained, 1'b1);
        tick();
        check("t5_wr30", {tbl_we, tbl_segment_index}, {1'b1, 11'd30});
        check("t5_redrain", cfg_drained, 1'b0);
        tick();
        check("t5_refrozen", cfg_drained, 1'b1);
        check("t5_cnt30", up_commit_cnt, 16'd10);
        cfg_freeze = 1'b0; bus.lk_valid = 1'b0;
        #1;
        check("t5_unfreeze_lk_ready", bus.lk_ready, 1'b1);
        tick();
        check("t5_unfreeze_drained", cfg_drained, 1'b0);

        // Reset with queued updates and a lookup in flight discards everything.
        bus.lk_valid = 1'b1; bus.lk_tag = 4'd4;
        bus.up_valid = 1'b1; bus.up_seg_index = 11'd40;
        tick();
        bus.lk_tag = 4'd5; bus.up_seg_index = 11'd41;
        tick();
        bus.lk_tag = 4'd6; bus.up_seg_index = 11'd42;
        tick();
        rst = 1'b1; bus.lk_valid = 1'b0; bus.up_valid = 1'b0;
        tick();
        check("t6_rst_we", tbl_we, 1'b0);
        check("t6_rst_res", res_valid, 1'b0);
        check("t6_rst_cnt", up_commit_cnt, 16'd0);
        check("t6_rst_up_ready", bus.up_ready, 1'b0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (tbl_we || res_valid) seen++;
        end
        check("t6_no_activity", seen, 0);
        check("t6_cnt", up_commit_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
